dm_bus_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single-ported data memory (dm_cs/dm_wr/dm_rd, Addr, D_In, DY_dat).
- Master 0 is the CPU; master 1 is the planned DMA engine.
- Grants one word access at a time with round-robin fairness and drives the memory strobes for exactly MEM_LAT cycles per access.
- Returns read data with a one-cycle done pulse. Sits between the masters and the Memory instance at top level.

---
 rtl/dm_arb_pkg.sv | 15 +
 rtl/dm_bus_arbiter_rr_pick2.sv | 23 ++
 rtl/dm_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/dm_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the master that did
// not win last time is chosen.
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M_CPU;
    case (req)
      2'b01:   winner = M_CPU;
      2'b10:   winner = M_DMA;
      2'b11:   winner = ~last;
      default: winner = M_CPU;
    endcase
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter/sequencer for the single-ported data memory: one word
// access at a time, strobes held MEM_LAT cycles, registered outputs.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] rdata,
  output logic          dm_cs,
  output logic          dm_wr,
  output logic          dm_rd,
  output logic [AW-1:0] Addr,
  output logic [DW-1:0] D_In,
  input  logic [DW-1:0] DY_dat,
  output logic          busy
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic          pick_valid;
  logic          pick_winner;
  logic          sel_wr;

  rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign sel_wr = (pick_winner == M_DMA) ? m1_wr : m0_wr;

  // The bus output registers double as the latched request: they are loaded
  // on grant, held through ACCESS and cleared when the access completes.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d              = pick_winner;
          last_d             = pick_winner;
          cnt_d              = CW'(MEM_LAT - 1);
          gnt_d[pick_winner] = 1'b1;
          cs_d               = 1'b1;
          wr_d               = sel_wr;
          rd_d               = ~sel_wr;
          addr_d             = (pick_winner == M_DMA) ? m1_addr : m0_addr;
          if (sel_wr) begin
            din_d = (pick_winner == M_DMA) ? m1_wdata : m0_wdata;
          end else begin
            din_d = '0;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (rd_q) begin
            rdata_d = DY_dat;
          end
          cs_d          = 1'b0;
          wr_d          = 1'b0;
          rd_d          = 1'b0;
          addr_d        = '0;
          din_d         = '0;
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= M_CPU;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign m0_gnt  = gnt_q[M_CPU];
  assign m1_gnt  = gnt_q[M_DMA];
  assign m0_done = done_q[M_CPU];
  assign m1_done = done_q[M_DMA];
  assign dm_cs   = cs_q;
  assign dm_wr   = wr_q;
  assign dm_rd   = rd_q;
  assign Addr    = addr_q;
  assign D_In    = din_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: cycle table on a MEM_LAT=1 instance, hand-written
// multi-cycle sequences on a MEM_LAT=3 instance, each with a small memory.
module tb_dm_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // MEM_LAT=1 instance (prefix a_)
  logic        a_rst, a_m0_req, a_m0_wr, a_m1_req, a_m1_wr;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done;
  logic [31:0] a_rdata, a_Addr, a_D_In, a_DY_dat;
  logic        a_dm_cs, a_dm_wr, a_dm_rd, a_busy;
  logic [31:0] mem_a [0:4095];

  // MEM_LAT=3 instance (prefix b_)
  logic        b_rst, b_m0_req, b_m0_wr, b_m1_req, b_m1_wr;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done;
  logic [31:0] b_rdata, b_Addr, b_D_In, b_DY_dat;
  logic        b_dm_cs, b_dm_wr, b_dm_rd, b_busy;
  logic [31:0] mem_b [0:4095];

  dm_bus_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
    .sys_clk(clk), .sys_rst(a_rst),
    .m0_req(a_m0_req), .m0_wr(a_m0_wr), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_done(a_m0_done),
    .m1_req(a_m1_req), .m1_wr(a_m1_wr), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_done(a_m1_done),
    .rdata(a_rdata), .dm_cs(a_dm_cs), .dm_wr(a_dm_wr), .dm_rd(a_dm_rd),
    .Addr(a_Addr), .D_In(a_D_In), .DY_dat(a_DY_dat), .busy(a_busy)
  );

  dm_bus_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) u_dut3 (
    .sys_clk(clk), .sys_rst(b_rst),
    .m0_req(b_m0_req), .m0_wr(b_m0_wr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done),
    .m1_req(b_m1_req), .m1_wr(b_m1_wr), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done),
    .rdata(b_rdata), .dm_cs(b_dm_cs), .dm_wr(b_dm_wr), .dm_rd(b_dm_rd),
    .Addr(b_Addr), .D_In(b_D_In), .DY_dat(b_DY_dat), .busy(b_busy)
  );

  // Memory models: combinational read, write on the clock edge while selected.
  assign a_DY_dat = (a_Addr[31:12] == '0) ? mem_a[a_Addr[11:0]] : 32'hBAD0BAD0;
  assign b_DY_dat = (b_Addr[31:12] == '0) ? mem_b[b_Addr[11:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (a_dm_cs && a_dm_wr && a_Addr[31:12] == '0) mem_a[a_Addr[11:0]] <= a_D_In;
    if (b_dm_cs && b_dm_wr && b_Addr[31:12] == '0) mem_b[b_Addr[11:0]] <= b_D_In;
  end

  typedef struct packed {
    logic        rst_n;
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [7:0]  flags;  // {g0, dn0, g1, dn1, cs, wr, rd, busy}
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic r0, input logic w0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [7:0] flags, input logic [31:0] addr,
                              input logic [31:0] din, input logic [31:0] rdata);
    vec_t v;
    v.rst_n = rst_n; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.flags = flags; v.addr = addr; v.din = din; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_idle();
    b_m0_req = 1'b0; b_m0_wr = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_wr = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
  endtask

  int   cs_cnt;
  logic gnt_order[$];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[12'h3F0] = 32'hDEADBEEF;
    mem_a[12'h020] = 32'hA5A50020;
    mem_a[12'h010] = 32'h5A5A0010;
    mem_b[12'h3F0] = 32'hCAFEF00D;
    mem_b[12'h3F4] = 32'h0BADBEEF;

    b_rst = 1'b0;
    b_idle();

    //          rst r0 w0 a0        d0            r1 w1 a1        d1            flags         addr      din           rdata
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h3F0, 32'hFFFFFFFF, 0, 0, 32'h0,   32'h0,        8'b1000_1011, 32'h3F0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h3F0, 32'hFFFFFFFF, 0, 0, 32'h0,   32'h0,        8'b0100_0001, 32'h0,   32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        1, 1, 32'h100, 32'h12345678, 8'b0010_1101, 32'h100, 32'h12345678, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        1, 1, 32'h100, 32'h12345678, 8'b0001_0001, 32'h0,   32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h100, 32'h0,        0, 0, 32'h0,   32'h0,        8'b1000_1011, 32'h100, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 0, 32'h100, 32'h0,        0, 0, 32'h0,   32'h0,        8'b0100_0001, 32'h0,   32'h0,        32'h12345678));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h12345678));
    vecs.push_back(mk(1, 1, 0, 32'h10,  32'h0,        1, 0, 32'h20,  32'h0,        8'b0010_1011, 32'h20,  32'h0,        32'h12345678));
    vecs.push_back(mk(1, 1, 0, 32'h10,  32'h0,        1, 0, 32'h20,  32'h0,        8'b0001_0001, 32'h0,   32'h0,        32'hA5A50020));
    vecs.push_back(mk(1, 1, 0, 32'h10,  32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hA5A50020));
    vecs.push_back(mk(1, 1, 0, 32'h10,  32'h0,        0, 0, 32'h0,   32'h0,        8'b1000_1011, 32'h10,  32'h0,        32'hA5A50020));
    vecs.push_back(mk(1, 1, 0, 32'h10,  32'h0,        0, 0, 32'h0,   32'h0,        8'b0100_0001, 32'h0,   32'h0,        32'h5A5A0010));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h5A5A0010));
    vecs.push_back(mk(1, 1, 1, 32'h40,  32'h11110000, 1, 1, 32'h44,  32'h22220000, 8'b0010_1101, 32'h44,  32'h22220000, 32'h5A5A0010));
    vecs.push_back(mk(1, 1, 1, 32'h40,  32'h11110000, 1, 1, 32'h44,  32'h22220000, 8'b0001_0001, 32'h0,   32'h0,        32'h5A5A0010));
    vecs.push_back(mk(1, 1, 1, 32'h40,  32'h11110000, 0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h5A5A0010));
    vecs.push_back(mk(1, 1, 1, 32'h40,  32'h11110000, 0, 0, 32'h0,   32'h0,        8'b1000_1101, 32'h40,  32'h11110000, 32'h5A5A0010));
    vecs.push_back(mk(1, 1, 1, 32'h40,  32'h11110000, 0, 0, 32'h0,   32'h0,        8'b0100_0001, 32'h0,   32'h0,        32'h5A5A0010));
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'h5A5A0010));

    for (int i = 0; i < vecs.size(); i++) begin
      a_rst = vecs[i].rst_n;
      a_m0_req = vecs[i].r0; a_m0_wr = vecs[i].w0; a_m0_addr = vecs[i].a0; a_m0_wdata = vecs[i].d0;
      a_m1_req = vecs[i].r1; a_m1_wr = vecs[i].w1; a_m1_addr = vecs[i].a1; a_m1_wdata = vecs[i].d1;
      tick();
      chk($sformatf("v%0d_m0_gnt", i),  a_m0_gnt,  vecs[i].flags[7]);
      chk($sformatf("v%0d_m0_done", i), a_m0_done, vecs[i].flags[6]);
      chk($sformatf("v%0d_m1_gnt", i),  a_m1_gnt,  vecs[i].flags[5]);
      chk($sformatf("v%0d_m1_done", i), a_m1_done, vecs[i].flags[4]);
      chk($sformatf("v%0d_dm_cs", i),   a_dm_cs,   vecs[i].flags[3]);
      chk($sformatf("v%0d_dm_wr", i),   a_dm_wr,   vecs[i].flags[2]);
      chk($sformatf("v%0d_dm_rd", i),   a_dm_rd,   vecs[i].flags[1]);
      chk($sformatf("v%0d_busy", i),    a_busy,    vecs[i].flags[0]);
      chk($sformatf("v%0d_Addr", i),    a_Addr,    vecs[i].addr);
      chk($sformatf("v%0d_D_In", i),    a_D_In,    vecs[i].din);
      chk($sformatf("v%0d_rdata", i),   a_rdata,   vecs[i].rdata);
    end
    chk("tbl_mem_w_m1", mem_a[12'h044], 32'h22220000);
    chk("tbl_mem_w_m0", mem_a[12'h040], 32'h11110000);

    // MEM_LAT=3: DMA write holds strobes exactly three cycles, done on the fourth edge.
    tick();
    b_rst = 1'b1;
    b_m1_req = 1'b1; b_m1_wr = 1'b1; b_m1_addr = 32'h100; b_m1_wdata = 32'h12345678;
    cs_cnt = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (b_dm_cs && b_dm_wr) cs_cnt++;
      chk($sformatf("dmaw_e%0d_m1_gnt", e),  b_m1_gnt,  e == 1);
      chk($sformatf("dmaw_e%0d_m1_done", e), b_m1_done, e == 4);
      chk($sformatf("dmaw_e%0d_cs", e),      b_dm_cs,   e <= 3);
      if (e <= 3) begin
        chk($sformatf("dmaw_e%0d_Addr", e), b_Addr, 32'h100);
        chk($sformatf("dmaw_e%0d_D_In", e), b_D_In, 32'h12345678);
      end
      if (e == 4) b_m1_req = 1'b0;
    end
    chk("dmaw_cs_cycles", cs_cnt, 3);
    chk("dmaw_busy_after", b_busy, 0);

    b_idle();
    b_m0_req = 1'b1; b_m0_addr = 32'h100;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("rdback_e%0d_m0_done", e), b_m0_done, e == 4);
      if (e == 4) begin
        chk("rdback_rdata", b_rdata, 32'h12345678);
        b_m0_req = 1'b0;
      end
    end
    tick();

    // Sustained simultaneous requests out of reset alternate m0, m1, m0, m1.
    b_rst = 1'b0;
    tick();
    chk("rr_reset_busy", b_busy, 0);
    b_rst = 1'b1;
    b_m0_req = 1'b1; b_m0_addr = 32'h3F0;
    b_m1_req = 1'b1; b_m1_addr = 32'h3F4;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("rr_e%0d_dual_gnt", e), b_m0_gnt & b_m1_gnt, 0);
      chk($sformatf("rr_e%0d_dual_done", e), b_m0_done & b_m1_done, 0);
      if (b_m0_gnt) gnt_order.push_back(1'b0);
      if (b_m1_gnt) gnt_order.push_back(1'b1);
    end
    b_idle();
    tick(); tick();
    chk("rr_grant_count", gnt_order.size(), 4);
    for (int g = 0; g < gnt_order.size(); g++) begin
      chk($sformatf("rr_grant%0d_master", g), gnt_order[g], g % 2);
    end

    // A request arriving during ACCESS waits until after the current done.
    b_m0_req = 1'b1; b_m0_addr = 32'h3F0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) begin
        b_m1_req = 1'b1; b_m1_addr = 32'h3F4;
      end
      chk($sformatf("late_e%0d_m0_done", e), b_m0_done, e == 4);
      chk($sformatf("late_e%0d_m1_gnt", e),  b_m1_gnt,  e == 6);
      if (e == 4) b_m0_req = 1'b0;
    end
    tick(); tick(); tick();
    chk("late_m1_done", b_m1_done, 1);
    chk("late_m1_rdata", b_rdata, 32'h0BADBEEF);
    b_idle();
    tick();

    // Reset in the second ACCESS cycle aborts; last returns to 1 so m0 wins the next tie.
    b_m0_req = 1'b1; b_m0_addr = 32'h200;
    tick();
    chk("rst_mid_gnt", b_m0_gnt, 1);
    tick();
    chk("rst_mid_cs_before", b_dm_cs, 1);
    b_rst = 1'b0;
    b_m1_req = 1'b1; b_m1_addr = 32'h3F4;
    tick();
    chk("rst_mid_cs",    b_dm_cs, 0);
    chk("rst_mid_wr",    b_dm_wr, 0);
    chk("rst_mid_rd",    b_dm_rd, 0);
    chk("rst_mid_Addr",  b_Addr,  0);
    chk("rst_mid_D_In",  b_D_In,  0);
    chk("rst_mid_rdata", b_rdata, 0);
    chk("rst_mid_busy",  b_busy,  0);
    chk("rst_mid_gnts",  {b_m0_gnt, b_m1_gnt}, 0);
    chk("rst_mid_dones", {b_m0_done, b_m1_done}, 0);
    b_rst = 1'b1;
    tick();
    chk("rst_tie_m0_gnt", b_m0_gnt, 1);
    chk("rst_tie_m1_gnt", b_m1_gnt, 0);
    chk("rst_tie_no_done", {b_m0_done, b_m1_done}, 0);
    tick(); tick(); tick();
    chk("rst_tie_m0_done", b_m0_done, 1);
    b_idle();
    tick(); tick();

    // Address change after grant has no effect on the access in flight.
    b_m0_req = 1'b1; b_m0_addr = 32'h3F0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) b_m0_addr = 32'h3F4;
      if (e <= 3) chk($sformatf("latch_e%0d_Addr", e), b_Addr, 32'h3F0);
      if (e == 4) begin
        chk("latch_done", b_m0_done, 1);
        chk("latch_rdata", b_rdata, 32'hCAFEF00D);
        b_m0_req = 1'b0;
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
